// File: rtl/smi_pkg.sv
// Shared types for the SMI transaction scheduler.
// Request bundle, FSM states and transaction owners.
package smi_pkg;

    localparam int PHY_W   = 5;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 16;
    localparam int ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        HOST,
        POLL
    } owner_t;

    typedef struct packed {
        logic              mode;
        logic [PHY_W-1:0]  phy;
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } smi_req_t;

endpackage

// File: rtl/smi_txn_scheduler_poll_timer.sv
// Free-running poll period counter.
// Emits a one-cycle tick every POLL_PERIOD enabled cycles.
module smi_poll_timer #(
    parameter int POLL_PERIOD = 50000000,
    parameter int PERIOD_W    = $clog2(POLL_PERIOD + 1)
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    // Count while enabled, wrap and tick at the end of the period.
    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q == PERIOD_W'(POLL_PERIOD - 1)) begin
            cnt_d  = '0;
            o_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/smi_txn_scheduler.sv
// Shares one SMI/MDIO engine between the host port and a status poller.
// Host wins arbitration; each transaction is bounded by a timeout.
module smi_txn_scheduler
    import smi_pkg::*;
#(
    parameter int POLL_PERIOD = 50000000,
    parameter int TIMEOUT     = 4096,
    parameter int PERIOD_W    = $clog2(POLL_PERIOD + 1),
    parameter int TO_W        = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_host_req,
    input  logic              i_host_mode,
    input  logic [PHY_W-1:0]  i_host_phy,
    input  logic [REG_W-1:0]  i_host_reg,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_busy,
    output logic              o_host_done,
    output logic              o_host_err,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_poll_en,
    input  logic [PHY_W-1:0]  i_poll_phy,
    input  logic [REG_W-1:0]  i_poll_reg,
    output logic              o_poll_valid,
    output logic [DATA_W-1:0] o_poll_data,
    output logic [ERR_W-1:0]  o_poll_err_cnt,
    output logic              o_mode,
    output logic [PHY_W-1:0]  o_phy_addr,
    output logic [REG_W-1:0]  o_reg_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_en,
    input  logic              i_dv,
    input  logic [DATA_W-1:0] i_rdata
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              host_pend_q, host_pend_d;
    logic              poll_pend_q, poll_pend_d;
    smi_req_t          host_req_q, host_req_d;
    smi_req_t          eng_q, eng_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              en_q, en_d;
    logic              host_done_q, host_done_d;
    logic              host_err_q, host_err_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              poll_valid_q, poll_valid_d;
    logic [DATA_W-1:0] poll_data_q, poll_data_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              poll_tick;
    logic              host_busy;
    logic              fin;
    logic              fin_err;

    smi_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD),
        .PERIOD_W    (PERIOD_W)
    ) u_poll_timer (
        .clk     (clk),
        .i_reset (i_reset),
        .i_en    (i_poll_en),
        .o_tick  (poll_tick)
    );

    assign host_busy = host_pend_q
                     | (owner_q == HOST && state_q != IDLE);

    // Request latching, arbitration and transaction sequencing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        host_pend_d  = host_pend_q;
        poll_pend_d  = poll_pend_q;
        host_req_d   = host_req_q;
        eng_d        = eng_q;
        to_cnt_d     = to_cnt_q;
        en_d         = 1'b0;
        host_done_d  = 1'b0;
        host_err_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        poll_valid_d = 1'b0;
        poll_data_d  = poll_data_q;
        err_cnt_d    = err_cnt_q;
        fin          = 1'b0;
        fin_err      = 1'b0;

        if (i_host_req && !host_busy) begin
            host_pend_d         = 1'b1;
            host_req_d.mode     = i_host_mode;
            host_req_d.phy      = i_host_phy;
            host_req_d.reg_addr = i_host_reg;
            host_req_d.data     = i_host_wdata;
        end

        if (!i_poll_en) begin
            poll_pend_d = 1'b0;
        end else if (poll_tick && !poll_pend_q) begin
            poll_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (host_pend_q) begin
                    owner_d     = HOST;
                    host_pend_d = 1'b0;
                    eng_d       = host_req_q;
                    en_d        = 1'b1;
                    state_d     = ISSUE;
                end else if (poll_pend_q && i_poll_en) begin
                    owner_d        = POLL;
                    poll_pend_d    = 1'b0;
                    eng_d.mode     = 1'b0;
                    eng_d.phy      = i_poll_phy;
                    eng_d.reg_addr = i_poll_reg;
                    eng_d.data     = '0;
                    en_d           = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (i_dv) begin
                    fin = 1'b1;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            state_d = DONE;
            if (owner_q == HOST) begin
                host_done_d = 1'b1;
                host_err_d  = fin_err;
                if (!fin_err && !eng_q.mode) begin
                    host_rdata_d = i_rdata;
                end
            end else if (!fin_err) begin
                poll_valid_d = 1'b1;
                poll_data_d  = i_rdata;
            end else if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            owner_q      <= HOST;
            host_pend_q  <= 1'b0;
            poll_pend_q  <= 1'b0;
            host_req_q   <= '0;
            eng_q        <= '0;
            to_cnt_q     <= '0;
            en_q         <= 1'b0;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
            host_rdata_q <= '0;
            poll_valid_q <= 1'b0;
            poll_data_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            host_pend_q  <= host_pend_d;
            poll_pend_q  <= poll_pend_d;
            host_req_q   <= host_req_d;
            eng_q        <= eng_d;
            to_cnt_q     <= to_cnt_d;
            en_q         <= en_d;
            host_done_q  <= host_done_d;
            host_err_q   <= host_err_d;
            host_rdata_q <= host_rdata_d;
            poll_valid_q <= poll_valid_d;
            poll_data_q  <= poll_data_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_host_busy    = host_busy;
    assign o_host_done    = host_done_q;
    assign o_host_err     = host_err_q;
    assign o_host_rdata   = host_rdata_q;
    assign o_poll_valid   = poll_valid_q;
    assign o_poll_data    = poll_data_q;
    assign o_poll_err_cnt = err_cnt_q;
    assign o_mode         = eng_q.mode;
    assign o_phy_addr     = eng_q.phy;
    assign o_reg_addr     = eng_q.reg_addr;
    assign o_data         = eng_q.data;
    assign o_en           = en_q;

endmodule
